// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the programmable clock divider run controller.
package clock_divider_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } div_state_t;

    localparam int MIN_DIVISOR = 2;

    function automatic int CeilLog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/divider_counter.sv
// Period counter for the clock divider: counts 0..D-1 while enabled and flags the D-1 cycle as tick.
module divider_counter #(
    parameter int NBITS_DIV = 26
) (
    input  logic                 clk_FPGA,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [NBITS_DIV-1:0] i_divisor,
    output logic                 o_tick
);

    logic [NBITS_DIV-1:0] r_count;
    logic                 w_atEnd;

    assign w_atEnd = (r_count == (i_divisor - NBITS_DIV'(1)));
    assign o_tick  = i_enable && w_atEnd;

    always_ff @(posedge clk_FPGA) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_atEnd ? '0 : r_count + NBITS_DIV'(1);
        end
    end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Run controller for the programmable clock divider (config handshake, start/stop/burst FSM).
// Define CLOCK_DIVIDER_CTRL_CLKOUT_EN to build the 50% clock_signal toggle flop; otherwise it is tied to 0.
module clock_divider_ctrl
    import clock_divider_pkg::*;
#(
    parameter int REFERENCE_CLOCK = 50_000_000,
    parameter int FREQUENCY       = 100,
    parameter int NBITS_DIV       = 26,
    parameter int NBITS_BURST     = 16
) (
    input  logic                   clk_FPGA,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [NBITS_DIV-1:0]   cfg_divisor,
    input  logic [NBITS_BURST-1:0] cfg_burst,
    input  logic                   start,
    input  logic                   stop,
    output logic                   tick,
    output logic                   clock_signal,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [NBITS_DIV-1:0] ResetDivisor = NBITS_DIV'(REFERENCE_CLOCK / FREQUENCY);

    div_state_t             r_state;
    logic [NBITS_DIV-1:0]   r_divisor;
    logic [NBITS_BURST-1:0] r_burst;
    logic [NBITS_BURST-1:0] r_tickCount;
    logic                   r_err;

    logic w_run;
    logic w_accept;
    logic w_cfgOk;
    logic w_tick;
    logic w_finalTick;
    logic w_leaveRun;

    assign w_run       = (r_state == RUN);
    assign cfg_ready   = !w_run;
    assign w_accept    = cfg_valid && cfg_ready;
    assign w_cfgOk     = (cfg_divisor >= NBITS_DIV'(MIN_DIVISOR));
    assign w_finalTick = w_tick && (r_burst != '0) && (r_tickCount == r_burst - NBITS_BURST'(1));
    assign w_leaveRun  = w_run && (stop || w_finalTick);

    divider_counter #(
        .NBITS_DIV(NBITS_DIV)
    ) u_counter (
        .clk_FPGA (clk_FPGA),
        .reset    (reset),
        .i_clear  (!w_run || stop),
        .i_enable (w_run),
        .i_divisor(r_divisor),
        .o_tick   (w_tick)
    );

    // A config offered together with start in ARMED wins; start must be re-presented afterwards.
    always_ff @(posedge clk_FPGA) begin
        if (reset) begin
            r_state   <= ARMED;
            r_divisor <= ResetDivisor;
            r_burst   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ARMED: begin
                    if (w_accept) begin
                        if (w_cfgOk) begin
                            r_divisor <= cfg_divisor;
                            r_burst   <= cfg_burst;
                            r_err     <= 1'b0;
                            r_state   <= ARMED;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else if ((r_state == ARMED) && start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_leaveRun) begin
                        r_state <= ARMED;
                    end
                end
                default: r_state <= ARMED;
            endcase
        end
    end

    always_ff @(posedge clk_FPGA) begin
        if (reset || !w_run || w_leaveRun) begin
            r_tickCount <= '0;
        end else if (w_tick && (r_burst != '0)) begin
            r_tickCount <= r_tickCount + NBITS_BURST'(1);
        end
    end

`ifdef CLOCK_DIVIDER_CTRL_CLKOUT_EN
    logic r_clkOut;

    // Leaving RUN for any reason parks the square wave low, even on a tick cycle.
    always_ff @(posedge clk_FPGA) begin
        if (reset) begin
            r_clkOut <= 1'b0;
        end else if (!w_run || stop || w_finalTick) begin
            r_clkOut <= 1'b0;
        end else if (w_tick) begin
            r_clkOut <= ~r_clkOut;
        end
    end

    assign clock_signal = r_clkOut;
`else
    assign clock_signal = 1'b0;
`endif

    assign tick = w_tick;
    assign busy = w_run;
    assign done = w_finalTick;
    assign err  = r_err;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Scoreboard bench for clock_divider_ctrl: a cycle model queues expected outputs, a negedge monitor compares.
module tb_clock_divider_ctrl;

    localparam int RefClock  = 1000;
    localparam int Freq      = 50;
    localparam int ResetDiv  = RefClock / Freq;
    localparam int NbitsDiv  = 26;
    localparam int NbitsBurst = 16;

    localparam int StIdle  = 0;
    localparam int StArmed = 1;
    localparam int StRun   = 2;

    typedef struct {
        logic tick;
        logic clk;
        logic busy;
        logic done;
        logic err;
        logic ready;
    } expOut_t;

    logic                  clk_FPGA;
    logic                  reset;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [NbitsDiv-1:0]   cfg_divisor;
    logic [NbitsBurst-1:0] cfg_burst;
    logic                  start;
    logic                  stop;
    logic                  tick;
    logic                  clock_signal;
    logic                  busy;
    logic                  done;
    logic                  err;

    expOut_t expQ[$];
    expOut_t monE;

    int nChecks;
    int nFail;

    int mState;
    int mDiv;
    int mBurst;
    int mCyc;
    int mTicks;
    logic mErr;
    logic mClk;

    clock_divider_ctrl #(
        .REFERENCE_CLOCK(RefClock),
        .FREQUENCY      (Freq),
        .NBITS_DIV      (NbitsDiv),
        .NBITS_BURST    (NbitsBurst)
    ) dut (
        .clk_FPGA    (clk_FPGA),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_divisor (cfg_divisor),
        .cfg_burst   (cfg_burst),
        .start       (start),
        .stop        (stop),
        .tick        (tick),
        .clock_signal(clock_signal),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk_FPGA = 1'b0;
    always #5 clk_FPGA = ~clk_FPGA;

    // Every comparison funnels through here so the summary counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s @%0t: got %0h, expected %0h", tag, $time, actual, expected);
        end
    endtask

    function automatic expOut_t modelOutputs();
        expOut_t e;
        e.tick  = (mState == StRun) && ((mCyc % mDiv) == 0);
        e.done  = e.tick && (mBurst != 0) && ((mTicks + 1) == mBurst);
        e.busy  = (mState == StRun);
        e.ready = (mState != StRun);
        e.err   = mErr;
`ifdef CLOCK_DIVIDER_CTRL_CLKOUT_EN
        e.clk   = mClk;
`else
        e.clk   = 1'b0;
`endif
        return e;
    endfunction

    task automatic modelReset();
        mState = StArmed;
        mDiv   = ResetDiv;
        mBurst = 0;
        mCyc   = 0;
        mTicks = 0;
        mErr   = 1'b0;
        mClk   = 1'b0;
    endtask

    // Advances the reference model across one rising edge using the inputs that were held over it.
    task automatic modelUpdate(input logic rst, input logic valid, input int div, input int burst,
                               input logic st, input logic sp, input expOut_t e);
        if (rst) begin
            modelReset();
        end else if (mState == StRun) begin
            if (sp || e.done) begin
                mState = StArmed;
                mClk   = 1'b0;
                mCyc   = 0;
                mTicks = 0;
            end else begin
                mCyc++;
                if (e.tick) begin
                    mTicks++;
                    mClk = ~mClk;
                end
            end
        end else if (valid) begin
            if (div >= 2) begin
                mDiv   = div;
                mBurst = burst;
                mErr   = 1'b0;
                mState = StArmed;
            end else begin
                mErr   = 1'b1;
                mState = StIdle;
            end
        end else if ((mState == StArmed) && st) begin
            mState = StRun;
            mCyc   = 1;
            mTicks = 0;
            mClk   = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic valid, input int div, input int burst,
                                 input logic st, input logic sp);
        expOut_t e;
        e = modelOutputs();
        expQ.push_back(e);
        reset       = rst;
        cfg_valid   = valid;
        cfg_divisor = NbitsDiv'(div);
        cfg_burst   = NbitsBurst'(burst);
        start       = st;
        stop        = sp;
        @(posedge clk_FPGA);
        modelUpdate(rst, valid, div, burst, st, sp, e);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic configure(input int div, input int burst);
        applyStimulus(1'b0, 1'b1, div, burst, 1'b0, 1'b0);
    endtask

    task automatic startRun();
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic stopRun();
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    always @(negedge clk_FPGA) begin
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            checkOutput("tick", 32'(tick), 32'(monE.tick));
            checkOutput("clock_signal", 32'(clock_signal), 32'(monE.clk));
            checkOutput("busy", 32'(busy), 32'(monE.busy));
            checkOutput("done", 32'(done), 32'(monE.done));
            checkOutput("err", 32'(err), 32'(monE.err));
            checkOutput("cfg_ready", 32'(cfg_ready), 32'(monE.ready));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nChecks     = 0;
        nFail       = 0;
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_divisor = '0;
        cfg_burst   = '0;
        start       = 1'b0;
        stop        = 1'b0;
        repeat (2) @(posedge clk_FPGA);
        #1;
        modelReset();
        $display("[TB] reset released, default divisor %0d", ResetDiv);

        // Default config, free-running from reset values
        startRun();
        idleCycles(2 * ResetDiv + 3);
        stopRun();
        idleCycles(2);

        // Finite burst of three ticks at divisor 4
        configure(4, 3);
        startRun();
        idleCycles(16);

        // Illegal divisor parks in IDLE and ignores start; a legal one recovers
        configure(1, 0);
        startRun();
        startRun();
        idleCycles(3);
        configure(5, 0);
        startRun();
        idleCycles(12);
        stopRun();
        idleCycles(2);

        // Stop on the second tick cycle of a free run
        configure(4, 0);
        startRun();
        idleCycles(7);
        stopRun();
        idleCycles(3);

        // Config held through RUN is taken only once back in ARMED
        configure(4, 2);
        startRun();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 6, 1, 1'b0, 1'b0);
        end
        idleCycles(1);
        startRun();
        idleCycles(8);

        // Config and start together: start is ignored, then honoured
        applyStimulus(1'b0, 1'b1, 3, 2, 1'b1, 1'b0);
        idleCycles(1);
        startRun();
        idleCycles(5);
        stopRun();
        idleCycles(2);

        // Stop coinciding with the final burst tick
        configure(3, 2);
        startRun();
        idleCycles(5);
        stopRun();
        idleCycles(2);

        // Reset mid-run restores the default divisor
        configure(4, 0);
        startRun();
        idleCycles(6);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idleCycles(2);
        startRun();
        idleCycles(ResetDiv + 2);

        @(negedge clk_FPGA);
        #1;
        checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
